lock_code_sender: RTL and testbench
===================================

Name: lock_code_sender

Overview:
Initiator side of the combination-lock entry interface. Captures a CODE_LEN-bit code on a start request, resets the lock, and presents digits one at a time on comb1/comb2 with single-cycle enter strobes. It then samples the lock's open/error response and reports pass, fail or timeout. It sits between host/test logic and the lock FSM, which samples comb/enter on clk.

Parameters:
CODE_LEN, 2, number of digits sent; code[0] first; 1..16
GAP_CYCLES, 2, enter-low cycles between strobes; 0..15
RESP_TIMEOUT, 8, max cycles waiting for open/error after last strobe; 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
code  in  CODE_LEN  combination, captured on accepted start
open  in  1  lock status: unlocked
error  in  1  lock status: error
lock_reset  out  1  one-cycle active-high synchronous reset to lock
comb1  out  1  current digit
comb2  out  1  current digit (same value as comb1)
enter  out  1  one-cycle digit strobe
busy  out  1  high from the cycle after accept through DONE
done  out  1  one-cycle completion pulse
pass  out  1  result: lock opened; held until next accept
fail  out  1  result: lock error; held until next accept
timeout  out  1  result: no response; held until next accept

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset (async, any state): state=IDLE; all outputs 0; digit index, gap counter and timeout counter cleared.
- States: IDLE, CLR, SETUP, STROBE, GAP, WAIT_RESP, DONE.
- IDLE:
  - start=1 -> capture code into a shift register, clear pass/fail/timeout, go to CLR.
  - start during any other state is ignored.
- CLR: lock_reset=1 for exactly 1 cycle -> SETUP.
- SETUP: comb1/comb2 = current digit, enter=0, 1 cycle -> STROBE.
- STROBE: enter=1 for 1 cycle; comb held stable.
  - Digits remaining: go to GAP. If GAP_CYCLES=0, go directly to SETUP.
  - Otherwise go to WAIT_RESP.
- GAP:
  - enter=0 and comb held for GAP_CYCLES cycles, then SETUP with the next digit.
  - error=1 during GAP is an early abort: fail=1 -> DONE.
- WAIT_RESP: counts cycles from 0; checks are prioritized as follows.
  - error=1 -> fail. This includes open=1 and error=1 together.
  - Otherwise open=1 -> pass.
  - Otherwise the counter reaching RESP_TIMEOUT-1 -> timeout.
  - Any of these -> DONE.
- DONE: done=1 for 1 cycle, busy=1 -> IDLE. Result flags persist.
- Exactly one of pass/fail/timeout is set after each done.
- Latency, defaults (CODE_LEN=2, GAP_CYCLES=2), lock answering the cycle after the last strobe:
  - start sampled in cycle 0; CLR 1; SETUP 2; STROBE 3; GAP 4-5; SETUP 6; STROBE 7; WAIT_RESP 8; done in cycle 9.
- comb1/comb2/enter are 0 in IDLE, CLR, WAIT_RESP and DONE.
- Counters never wrap. The digit index stops at CODE_LEN-1.

Optional Feature:
LOCK_SENDER_LOCKOUT_EN
- Defined:
  - 2-bit consecutive-fail counter; incremented on fail; cleared on pass. Timeout leaves it unchanged.
  - On the 3rd consecutive fail, extra output locked_out=1 and all start requests are ignored until reset.
- Undefined: no counter, no locked_out port, no lockout.

Decomposition:
- Package lock_pkg: state encoding (7 states, 3-bit), result enum (NONE/PASS/FAIL/TIMEOUT), and default parameter constants.
- One sub-module, lock_gap_timer: loadable down-counter with a zero flag. It is shared by GAP and WAIT_RESP (loaded with GAP_CYCLES or RESP_TIMEOUT).

Test Plan:
- Correct code: code=2'b11, lock model opens after 2 strobes -> enter high in cycles 3 and 7, comb=1 in both, done cycle 9, pass=1.
- Wrong first digit: code=2'b10, lock error after first strobe -> GAP abort, done in cycle 5, fail=1, only one enter pulse.
- Silent lock: open=error=0 throughout -> timeout=1, done 8 cycles after WAIT_RESP entry.
- GAP_CYCLES=0: strobes in consecutive STROBE/SETUP cycles (3, 5); start pulsed while busy is ignored.
- Reset pulled low during GAP -> all outputs 0 immediately; the next start runs a full sequence from CLR.
- With LOCKOUT_EN: 3 fail runs -> locked_out=1, 4th start ignored (busy stays 0); after reset, locked_out=0.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: shared types and defaults for the combination-lock code sender.
package lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_SETUP,
      ST_STROBE,
      ST_GAP,
      ST_WAIT_RESP,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_PASS,
      RES_FAIL,
      RES_TIMEOUT
   } result_e;

   localparam int unsigned DEF_CODE_LEN     = 2;
   localparam int unsigned DEF_GAP_CYCLES   = 2;
   localparam int unsigned DEF_RESP_TIMEOUT = 8;

   // Wide enough for RESP_TIMEOUT-1 (max 254) and GAP_CYCLES-1 (max 14).
   localparam int unsigned TIMER_W = 8;

   // Down-counter load value giving exactly `cycles` cycles until the zero flag.
   function automatic logic [TIMER_W-1:0] timer_load_val(input int unsigned cycles);
      return (cycles > 0) ? TIMER_W'(cycles - 1) : '0;
   endfunction

endpackage

// File: rtl/lock_gap_timer.sv
// lock_gap_timer: loadable down-counter with zero flag, shared by the
// inter-digit gap and the response timeout. Saturates at zero.
module lock_gap_timer
   import lock_pkg::*;
#(
   parameter int unsigned W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load has priority over decrement; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_code_sender.sv
// lock_code_sender: sends a CODE_LEN-digit code to the lock FSM one digit per
// enter strobe, then reports pass / fail / timeout from the lock's response.
// Optional build macro LOCK_SENDER_LOCKOUT_EN adds a consecutive-fail lockout
// and the locked_out output.
module lock_code_sender
   import lock_pkg::*;
#(
   parameter int unsigned CODE_LEN     = DEF_CODE_LEN,
   parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int unsigned RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CODE_LEN-1:0] code,
   input  logic                open,
   input  logic                error,
   output logic                lock_reset,
   output logic                comb1,
   output logic                comb2,
   output logic                enter,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic                timeout
`ifdef LOCK_SENDER_LOCKOUT_EN
   ,output logic               locked_out
`endif
);

   localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_LEN - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD  = timer_load_val(GAP_CYCLES);
   localparam logic [TIMER_W-1:0] RESP_LOAD = timer_load_val(RESP_TIMEOUT);

   state_e               state_q, state_d;
   logic [CODE_LEN-1:0]  shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   result_e              res_q, res_d;

   logic                 last_digit;
   logic                 start_ok;
   logic                 timer_load;
   logic                 timer_dec;
   logic [TIMER_W-1:0]   timer_val;
   logic                 timer_zero;
   logic                 digit_out;

   assign last_digit = (idx_q == LAST_IDX);

`ifdef LOCK_SENDER_LOCKOUT_EN
   logic [1:0] fails_q, fails_d;
   assign locked_out = (fails_q == 2'd3);
   assign start_ok   = start && !locked_out;
`else
   assign start_ok   = start;
`endif

   lock_gap_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk        (clk),
      .rst_ni     (reset),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .dec_i      (timer_dec),
      .zero_o     (timer_zero)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         res_q   <= RES_NONE;
`ifdef LOCK_SENDER_LOCKOUT_EN
         fails_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
`ifdef LOCK_SENDER_LOCKOUT_EN
         fails_q <= fails_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (start_ok) state_d = ST_CLR;
         ST_CLR:       state_d = ST_SETUP;
         ST_SETUP:     state_d = ST_STROBE;
         ST_STROBE: begin
            if (last_digit)            state_d = ST_WAIT_RESP;
            else if (GAP_CYCLES == 0)  state_d = ST_SETUP;
            else                       state_d = ST_GAP;
         end
         ST_GAP: begin
            if (error)           state_d = ST_DONE;
            else if (timer_zero) state_d = ST_SETUP;
         end
         ST_WAIT_RESP: if (error || open || timer_zero) state_d = ST_DONE;
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: code shift, digit index, result, timer control.
   // The shift happens on the way into SETUP so comb stays stable through GAP.
   always_comb begin
      shift_d    = shift_q;
      idx_d      = idx_q;
      res_d      = res_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      timer_val  = GAP_LOAD;
`ifdef LOCK_SENDER_LOCKOUT_EN
      fails_d    = fails_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               shift_d = code;
               idx_d   = '0;
               res_d   = RES_NONE;
            end
         end
         ST_STROBE: begin
            timer_load = 1'b1;
            timer_val  = last_digit ? RESP_LOAD : GAP_LOAD;
            if (!last_digit && (GAP_CYCLES == 0)) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
            end
         end
         ST_GAP: begin
            timer_dec = 1'b1;
            if (error) begin
               res_d = RES_FAIL;
            end else if (timer_zero) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
            end
         end
         ST_WAIT_RESP: begin
            timer_dec = 1'b1;
            if (error)           res_d = RES_FAIL;
            else if (open)       res_d = RES_PASS;
            else if (timer_zero) res_d = RES_TIMEOUT;
         end
`ifdef LOCK_SENDER_LOCKOUT_EN
         ST_DONE: begin
            if (res_q == RES_PASS) begin
               fails_d = '0;
            end else if ((res_q == RES_FAIL) && (fails_q != 2'd3)) begin
               fails_d = fails_q + 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      lock_reset = 1'b0;
      digit_out  = 1'b0;
      enter      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         ST_CLR:       begin lock_reset = 1'b1; busy = 1'b1; end
         ST_SETUP:     begin digit_out = shift_q[0]; busy = 1'b1; end
         ST_STROBE:    begin digit_out = shift_q[0]; enter = 1'b1; busy = 1'b1; end
         ST_GAP:       begin digit_out = shift_q[0]; busy = 1'b1; end
         ST_WAIT_RESP: busy = 1'b1;
         ST_DONE:      begin done = 1'b1; busy = 1'b1; end
         default: ;
      endcase
   end

   assign comb1   = digit_out;
   assign comb2   = digit_out;
   assign pass    = (res_q == RES_PASS);
   assign fail    = (res_q == RES_FAIL);
   assign timeout = (res_q == RES_TIMEOUT);

endmodule

// File: tb/tb_lock_code_sender.sv
// tb_lock_code_sender: directed bench for lock_code_sender. Two instances:
// default gap (dut_a) and zero gap (dut_b). Expected run outcomes are queued
// when a start is driven and popped when the run's done pulse is seen.
module tb_lock_code_sender;

   localparam int MAXC = 28;

   typedef struct {
      int          done_cyc;
      logic [2:0]  res;        // {pass, fail, timeout}
      logic [31:0] en_mask;    // cycles with enter high
      logic [31:0] comb_mask;  // cycles with comb high
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic [1:0] code;
   logic       lk_open, lk_error;

   logic lr_a, c1_a, c2_a, en_a, busy_a, done_a, pass_a, fail_a, to_a;
   logic lr_b, c1_b, c2_b, en_b, busy_b, done_b, pass_b, fail_b, to_b;
`ifdef LOCK_SENDER_LOCKOUT_EN
   logic locked_out_a, locked_out_b;
`endif

   logic [8:0] o_a, o_b;
   assign o_a = {lr_a, c1_a, c2_a, en_a, busy_a, done_a, pass_a, fail_a, to_a};
   assign o_b = {lr_b, c1_b, c2_b, en_b, busy_b, done_b, pass_b, fail_b, to_b};

   always #5 clk = ~clk;

   lock_code_sender #(.CODE_LEN(2), .GAP_CYCLES(2), .RESP_TIMEOUT(8)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .code(code),
      .open(lk_open), .error(lk_error),
      .lock_reset(lr_a), .comb1(c1_a), .comb2(c2_a), .enter(en_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(to_a)
`ifdef LOCK_SENDER_LOCKOUT_EN
      ,.locked_out(locked_out_a)
`endif
   );

   lock_code_sender #(.CODE_LEN(2), .GAP_CYCLES(0), .RESP_TIMEOUT(8)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .code(code),
      .open(lk_open), .error(lk_error),
      .lock_reset(lr_b), .comb1(c1_b), .comb2(c2_b), .enter(en_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(to_b)
`ifdef LOCK_SENDER_LOCKOUT_EN
      ,.locked_out(locked_out_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One start-to-done transaction. Cycle 0 is the cycle start is sampled.
   // The lock model answers with resp={open,error} from the cycle after the
   // n-th strobe (n=0: never answers). poke>0 re-pulses start in that cycle.
   task automatic run(input string tag, input bit which, input logic [1:0] c,
                      input logic [1:0] resp, input int n, input int poke, input exp_t e);
      exp_t        x;
      logic [31:0] m_en, m_c1, m_c2, m_busy, m_lr, m_done;
      logic [2:0]  r_start, r_done, r_held;
      logic [8:0]  o;
      int          dc, seen;
      bit          respond;
      sb.push_back(e);
      m_en = '0; m_c1 = '0; m_c2 = '0; m_busy = '0; m_lr = '0; m_done = '0;
      r_start = 3'b111; r_done = 3'b111; r_held = 3'b111;
      dc = -1; seen = 0; respond = 1'b0;
      @(negedge clk);
      code = c;
      if (which) start_b = 1'b1; else start_a = 1'b1;
      for (int cy = 1; cy <= MAXC; cy++) begin
         @(negedge clk);
         if (cy == 1) begin start_a = 1'b0; start_b = 1'b0; end
         if (poke > 0 && cy == poke) begin
            if (which) start_b = 1'b1; else start_a = 1'b1;
         end
         if (poke > 0 && cy == poke + 1) begin start_a = 1'b0; start_b = 1'b0; end
         if (respond) begin lk_open = resp[1]; lk_error = resp[0]; end
         o = which ? o_b : o_a;
         if (cy == 1) r_start = o[2:0];
         m_lr[cy] = o[8]; m_c1[cy] = o[7]; m_c2[cy] = o[6];
         m_en[cy] = o[5]; m_busy[cy] = o[4]; m_done[cy] = o[3];
         if (o[5]) begin
            seen++;
            if (seen == n) respond = 1'b1;
         end
         if (o[3] && dc < 0) begin dc = cy; r_done = o[2:0]; end
         if (dc >= 0 && cy == dc + 2) r_held = o[2:0];
         if (dc >= 0 && cy == dc + 3) break;
      end
      lk_open = 1'b0; lk_error = 1'b0;
      x = sb.pop_front();
      chk({tag, "_done_cycle"}, m_done, 32'd1 << x.done_cyc);
      chk({tag, "_result"}, {29'd0, r_done}, {29'd0, x.res});
      chk({tag, "_result_held"}, {29'd0, r_held}, {29'd0, x.res});
      chk({tag, "_result_cleared"}, {29'd0, r_start}, 32'd0);
      chk({tag, "_enter"}, m_en, x.en_mask);
      chk({tag, "_comb1"}, m_c1, x.comb_mask);
      chk({tag, "_comb2"}, m_c2, x.comb_mask);
      chk({tag, "_busy"}, m_busy, ((32'd1 << (x.done_cyc + 1)) - 32'd1) & ~32'd1);
      chk({tag, "_lock_reset"}, m_lr, 32'h2);
   endtask

   initial begin
      logic [31:0] acc;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      code = 2'b00; lk_open = 1'b0; lk_error = 1'b0;
      #1 reset = 1'b0;
      #10;
      chk("reset_a", {23'd0, o_a}, 32'd0);
      chk("reset_b", {23'd0, o_b}, 32'd0);
      @(negedge clk) reset = 1'b1;

      run("correct",  1'b0, 2'b11, 2'b10, 2, 0, exp_t'{9,  3'b100, 32'h88, 32'hFC});
      run("wrong",    1'b0, 2'b10, 2'b01, 1, 0, exp_t'{5,  3'b010, 32'h08, 32'h00});
      run("silent",   1'b0, 2'b01, 2'b00, 0, 0, exp_t'{16, 3'b001, 32'h88, 32'h3C});
      run("both",     1'b0, 2'b11, 2'b11, 2, 0, exp_t'{9,  3'b010, 32'h88, 32'hFC});
      run("gap0",     1'b1, 2'b11, 2'b10, 2, 4, exp_t'{7,  3'b100, 32'h28, 32'h3C});

      // Reset asserted while dut_a sits in GAP.
      @(negedge clk); code = 2'b11; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (3) @(negedge clk);
      chk("gap_before_reset", {30'd0, o_a[7], o_a[4]}, 32'd3);
      #2 reset = 1'b0;
      #1 chk("reset_mid_gap", {23'd0, o_a}, 32'd0);
      @(negedge clk) reset = 1'b1;
      run("after_reset", 1'b0, 2'b11, 2'b10, 2, 0, exp_t'{9, 3'b100, 32'h88, 32'hFC});

`ifdef LOCK_SENDER_LOCKOUT_EN
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         run("lockout_fail", 1'b0, 2'b10, 2'b01, 1, 0, exp_t'{5, 3'b010, 32'h08, 32'h00});
         chk("locked_out_level", {31'd0, locked_out_a}, (k == 3) ? 32'd1 : 32'd0);
      end
      acc = '0;
      @(negedge clk); code = 2'b11; start_a = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         start_a = 1'b0;
         acc = acc | {31'd0, busy_a};
      end
      chk("locked_start_ignored", acc, 32'd0);
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      #1 chk("locked_out_cleared", {31'd0, locked_out_a}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
